// File: rtl/huffman_bit_aligner.sv
// Bit aligner in front of the Huffman decoder: packs incoming words into a
// left-aligned bit buffer and presents an MSB-first sliding decode window.
module huffman_bit_aligner #(
    parameter int WORD_WIDTH = 32,
    parameter int WIN_WIDTH  = 16,
    parameter int BUF_WIDTH  = 64,
    parameter int LVL_W      = $clog2(BUF_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIN_WIDTH-1:0]  window,
    output logic                  window_valid,
    input  logic                  consume,
    input  logic [3:0]            consume_len,
    output logic [LVL_W-1:0]      level,
    output logic [31:0]           bits_consumed,
    output logic                  underflow_err,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_VALID   = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [BUF_WIDTH-1:0]  r_buf;
    logic [LVL_W-1:0]      r_level;
    logic [31:0]           r_bits_consumed;
    logic                  r_underflow;

    logic                  w_window_valid;
    logic                  w_consume_ok;
    logic                  w_underflow_req;
    logic                  w_load;
    logic [LVL_W-1:0]      w_cons_amt;
    logic [LVL_W-1:0]      w_level_after_c;
    logic [LVL_W-1:0]      w_level_next;
    logic [BUF_WIDTH-1:0]  w_buf_after_c;
    logic [BUF_WIDTH-1:0]  w_word_aligned;
    logic [BUF_WIDTH-1:0]  w_buf_next;

    assign w_window_valid = (r_level >= LVL_W'(WIN_WIDTH));
    assign in_ready       = (r_level <= LVL_W'(WORD_WIDTH)) && (r_state != ST_FLUSH);
    assign window         = r_buf[BUF_WIDTH-1 -: WIN_WIDTH];
    assign window_valid   = w_window_valid;
    assign level          = r_level;
    assign bits_consumed  = r_bits_consumed;
    assign underflow_err  = r_underflow;
    assign dbg_state      = r_state;

    // Consume is applied before the load so a same-edge word lands right
    // behind whatever survives the shift.
    always_comb begin
        w_consume_ok    = consume && w_window_valid;
        w_underflow_req = consume && !w_window_valid && (consume_len != 4'd0);
        w_load          = in_valid && in_ready;
        w_cons_amt      = w_consume_ok ? LVL_W'(consume_len) : '0;
        w_level_after_c = r_level - w_cons_amt;
        w_buf_after_c   = r_buf << w_cons_amt;
        w_word_aligned  = '0;
        if (w_load) begin
            w_word_aligned = {in_data, {(BUF_WIDTH-WORD_WIDTH){1'b0}}} >> w_level_after_c;
        end
        w_buf_next   = w_buf_after_c | w_word_aligned;
        w_level_next = w_level_after_c + (w_load ? LVL_W'(WORD_WIDTH) : '0);
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_FLUSH;
        end else if (r_state == ST_FLUSH) begin
            w_state_next = ST_EMPTY;
        end else if (w_level_next == '0) begin
            w_state_next = ST_EMPTY;
        end else if (w_level_next < LVL_W'(WIN_WIDTH)) begin
            w_state_next = ST_PARTIAL;
        end else begin
            w_state_next = ST_VALID;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_EMPTY;
            r_buf           <= '0;
            r_level         <= '0;
            r_bits_consumed <= '0;
            r_underflow     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_buf       <= '0;
                r_level     <= '0;
                r_underflow <= 1'b0;
            end else begin
                r_buf           <= w_buf_next;
                r_level         <= w_level_next;
                r_bits_consumed <= r_bits_consumed + 32'(w_cons_amt);
                if (w_underflow_req) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_bit_aligner.sv
// Bench for huffman_bit_aligner: vector table, directed corner sequences and
// a randomized run against a bit-queue reference model.
module tb_huffman_bit_aligner;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] window;
    logic        window_valid;
    logic        consume;
    logic [3:0]  consume_len;
    logic [6:0]  level;
    logic [31:0] bits_consumed;
    logic        underflow_err;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_errors;

    huffman_bit_aligner dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .window        (window),
        .window_valid  (window_valid),
        .consume       (consume),
        .consume_len   (consume_len),
        .level         (level),
        .bits_consumed (bits_consumed),
        .underflow_err (underflow_err),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic fl,
                         input logic c, input logic [3:0] len);
        in_valid    = iv;
        in_data     = d;
        flush       = fl;
        consume     = c;
        consume_len = len;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    endtask

    // Reference model: the stream as a queue of bits, oldest at index 0.
    bit          m_q[$];
    int unsigned m_bc;
    bit          m_uf;
    bit          m_fl;

    function automatic void model_reset();
        m_q.delete();
        m_bc = 0;
        m_uf = 1'b0;
        m_fl = 1'b0;
    endfunction

    function automatic void model_apply();
        bit ready_pre;
        ready_pre = (m_q.size() <= 32) && !m_fl;
        if (flush) begin
            m_q.delete();
            m_uf = 1'b0;
            m_fl = 1'b1;
        end else begin
            m_fl = 1'b0;
            if (consume) begin
                if (m_q.size() >= 16) begin
                    for (int i = 0; i < int'(consume_len); i++) void'(m_q.pop_front());
                    m_bc = m_bc + consume_len;
                end else if (consume_len != 4'd0) begin
                    m_uf = 1'b1;
                end
            end
            if (in_valid && ready_pre) begin
                for (int i = 31; i >= 0; i--) m_q.push_back(in_data[i]);
            end
        end
    endfunction

    task automatic check_model(input int cyc);
        logic [15:0] w;
        logic [1:0]  st;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < m_q.size()) w[15-i] = m_q[i];
        end
        if (m_fl)                 st = 2'd3;
        else if (m_q.size() == 0) st = 2'd0;
        else if (m_q.size() < 16) st = 2'd1;
        else                      st = 2'd2;
        check($sformatf("rnd%0d level", cyc), 64'(level), 64'(m_q.size()));
        check($sformatf("rnd%0d window", cyc), 64'(window), 64'(w));
        check($sformatf("rnd%0d wvalid", cyc), 64'(window_valid), 64'(m_q.size() >= 16));
        check($sformatf("rnd%0d ready", cyc), 64'(in_ready), 64'((m_q.size() <= 32) && !m_fl));
        check($sformatf("rnd%0d bc", cyc), 64'(bits_consumed), 64'(m_bc));
        check($sformatf("rnd%0d uf", cyc), 64'(underflow_err), 64'(m_uf));
        check($sformatf("rnd%0d state", cyc), 64'(dbg_state), 64'(st));
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        c;
        logic [3:0]  len;
        logic [6:0]  lvl;
        logic [15:0] win;
        logic        wv;
        logic        rdy;
        logic [31:0] bc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle();

        tbl[0] = '{1'b1, 32'hA5C30F96, 1'b0, 4'd0,  7'd32, 16'hA5C3, 1'b1, 1'b1, 32'd0};
        tbl[1] = '{1'b0, 32'h0,        1'b1, 4'd4,  7'd28, 16'h5C30, 1'b1, 1'b1, 32'd4};
        tbl[2] = '{1'b0, 32'h0,        1'b1, 4'd12, 7'd16, 16'h0F96, 1'b1, 1'b1, 32'd16};
        tbl[3] = '{1'b1, 32'h12345678, 1'b1, 4'd15, 7'd33, 16'h091A, 1'b1, 1'b0, 32'd31};
        tbl[4] = '{1'b1, 32'hFFFFFFFF, 1'b0, 4'd0,  7'd33, 16'h091A, 1'b1, 1'b0, 32'd31};
        tbl[5] = '{1'b1, 32'hFFFFFFFF, 1'b1, 4'd1,  7'd32, 16'h1234, 1'b1, 1'b1, 32'd32};
        tbl[6] = '{1'b1, 32'hFFFFFFFF, 1'b0, 4'd0,  7'd64, 16'h1234, 1'b1, 1'b0, 32'd32};
        tbl[7] = '{1'b1, 32'hFFFFFFFF, 1'b1, 4'd8,  7'd56, 16'h3456, 1'b1, 1'b0, 32'd40};

        // Reset and idle
        do_reset();
        step();
        check("rst level", 64'(level), 64'd0);
        check("rst window", 64'(window), 64'h0);
        check("rst wvalid", 64'(window_valid), 64'd0);
        check("rst ready", 64'(in_ready), 64'd1);
        check("rst state", 64'(dbg_state), 64'd0);
        check("rst bc", 64'(bits_consumed), 64'd0);
        check("rst uf", 64'(underflow_err), 64'd0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].iv, tbl[i].d, 1'b0, tbl[i].c, tbl[i].len);
            step();
            check($sformatf("vec%0d level", i), 64'(level), 64'(tbl[i].lvl));
            check($sformatf("vec%0d window", i), 64'(window), 64'(tbl[i].win));
            check($sformatf("vec%0d wvalid", i), 64'(window_valid), 64'(tbl[i].wv));
            check($sformatf("vec%0d ready", i), 64'(in_ready), 64'(tbl[i].rdy));
            check($sformatf("vec%0d bc", i), 64'(bits_consumed), 64'(tbl[i].bc));
        end

        // Consume and load on the same edge
        do_reset();
        drive(1'b1, 32'hA5C30F96, 1'b0, 1'b0, 4'd0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd8); step();
        check("cl pre level", 64'(level), 64'd24);
        check("cl pre window", 64'(window), 64'hC30F);
        drive(1'b1, 32'h12345678, 1'b0, 1'b1, 4'd8); step();
        check("cl level", 64'(level), 64'd48);
        check("cl window", 64'(window), 64'h0F96);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd15); step();
        check("cl c15 level", 64'(level), 64'd33);
        check("cl c15 window", 64'(window), 64'h091A);

        // Backpressure above 32 bits
        do_reset();
        drive(1'b1, 32'h11111111, 1'b0, 1'b0, 4'd0); step();
        drive(1'b1, 32'h22222222, 1'b0, 1'b0, 4'd0); step();
        check("bp full level", 64'(level), 64'd64);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd15); step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd9); step();
        check("bp level40", 64'(level), 64'd40);
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0); step();
        check("bp hold level", 64'(level), 64'd40);
        check("bp hold ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 4'd8); step();
        check("bp c8 level", 64'(level), 64'd32);
        check("bp c8 ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0); step();
        check("bp acc level", 64'(level), 64'd64);
        check("bp acc window", 64'(window), 64'h2222);
        idle();

        // Underflow then flush (simultaneous load dropped)
        do_reset();
        drive(1'b1, 32'hF0F0F0F0, 1'b0, 1'b0, 4'd0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd15); step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd7); step();
        check("uf pre level", 64'(level), 64'd10);
        check("uf pre window", 64'(window), 64'h3C00);
        check("uf pre state", 64'(dbg_state), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd3); step();
        check("uf level", 64'(level), 64'd10);
        check("uf window", 64'(window), 64'h3C00);
        check("uf flag", 64'(underflow_err), 64'd1);
        check("uf bc", 64'(bits_consumed), 64'd22);
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd2); step();
        check("fl level", 64'(level), 64'd0);
        check("fl window", 64'(window), 64'h0);
        check("fl uf", 64'(underflow_err), 64'd0);
        check("fl ready", 64'(in_ready), 64'd0);
        check("fl state", 64'(dbg_state), 64'd3);
        check("fl bc", 64'(bits_consumed), 64'd22);
        idle(); step();
        check("fl after state", 64'(dbg_state), 64'd0);
        check("fl after ready", 64'(in_ready), 64'd1);
        check("fl after level", 64'(level), 64'd0);

        // Asynchronous reset mid-operation
        do_reset();
        drive(1'b1, 32'hA5C30F96, 1'b0, 1'b0, 4'd0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd8); step();
        drive(1'b1, 32'h12345678, 1'b0, 1'b1, 4'd8); step();
        check("ar pre level", 64'(level), 64'd48);
        drive(1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 4'd4);
        #2;
        rst = 1'b1;
        #1;
        check("ar level", 64'(level), 64'd0);
        check("ar window", 64'(window), 64'h0);
        check("ar bc", 64'(bits_consumed), 64'd0);
        check("ar ready", 64'(in_ready), 64'd1);
        check("ar state", 64'(dbg_state), 64'd0);
        step();
        check("ar held level", 64'(level), 64'd0);
        rst = 1'b0;
        model_reset();
        drive(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 4'd0); step();
        check("ar first level", 64'(level), 64'd32);
        check("ar first window", 64'(window), 64'hCAFE);

        // Randomized run against the model
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
            model_apply();
            step();
            check_model(cyc);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
